// File: rtl/pbkdf2_pass_gen.sv
// pbkdf2_pass_gen: odometer-order password candidate generator feeding the PBKDF2-HMAC-Whirlpool core.
// Define PASS_GEN_RESUME_EN to add i_resume_digits, letting a run start from a given odometer position.
module pbkdf2_pass_gen #(
    parameter int MAX_LEN      = 12,
    parameter int CHARSET_SIZE = 62,
    parameter int DIGIT_W      = 6
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic [3:0]                   i_min_len,
    input  logic [3:0]                   i_max_len,
`ifdef PASS_GEN_RESUME_EN
    input  logic [MAX_LEN*DIGIT_W-1:0]   i_resume_digits,
`endif
    input  logic                         i_pass_ready,
    output logic                         o_pass_valid,
    output logic [191:0]                 o_pass,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [47:0]                  o_count
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PRESENT, S_ADVANCE, S_DONE} state_t;
    localparam logic [DIGIT_W-1:0] ZERO [MAX_LEN] = '{default: '0};
    state_t state, state_nxt;
    logic [DIGIT_W-1:0] digits [MAX_LEN];
    logic [DIGIT_W-1:0] inc_digits [MAX_LEN];
    logic [DIGIT_W-1:0] start_digits [MAX_LEN];
    logic [3:0] len, max_len;
    logic carry, cfg_bad, take;
    function automatic logic [7:0] char_of(input logic [DIGIT_W-1:0] d);
        return d < 10 ? 8'h30 + 8'(d) : d < 36 ? 8'h57 + 8'(d) : 8'h1D + 8'(d);
    endfunction
    function automatic logic [191:0] pack(input logic [DIGIT_W-1:0] d [MAX_LEN], input logic [3:0] n);
        logic [191:0] p;
        p = '0;
        for (int k = 0; k < MAX_LEN; k++)
            if (k < int'(n)) p[191-16*k -: 8] = char_of(d[k]);
        return p;
    endfunction
    assign cfg_bad = i_min_len == 4'd0 || i_min_len > i_max_len || i_max_len > 4'(MAX_LEN);
    assign take    = o_pass_valid && i_pass_ready;
    assign o_busy  = state inside {S_LOAD, S_PRESENT, S_ADVANCE};
    // Odometer step: the rightmost active digit is least significant.
    always_comb begin
        carry = 1'b1;
        for (int i = MAX_LEN - 1; i >= 0; i--) begin
            inc_digits[i] = digits[i];
            if (carry && i < int'(len)) begin
                carry = digits[i] == DIGIT_W'(CHARSET_SIZE - 1);
                inc_digits[i] = carry ? '0 : digits[i] + 1'b1;
            end
        end
    end
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
`ifdef PASS_GEN_RESUME_EN
            start_digits[i] = i_resume_digits[(MAX_LEN-1-i)*DIGIT_W +: DIGIT_W];
            if (start_digits[i] >= DIGIT_W'(CHARSET_SIZE)) start_digits[i] = DIGIT_W'(CHARSET_SIZE - 1);
`else
            start_digits[i] = '0;
`endif
        end
    end
    always_comb begin
        state_nxt = state;
        if (i_abort) state_nxt = S_IDLE;
        else case (state)
            S_IDLE, S_DONE: if (i_start) state_nxt = cfg_bad ? S_DONE : S_LOAD;
            S_LOAD:         state_nxt = S_PRESENT;
            S_PRESENT:      if (take) state_nxt = S_ADVANCE;
            S_ADVANCE:      state_nxt = (carry && len == max_len) ? S_DONE : S_PRESENT;
            default:        state_nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_rstn) state <= S_IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            digits       <= ZERO;
            len          <= '0;
            max_len      <= '0;
            o_pass_valid <= 1'b0;
            o_pass       <= '0;
            o_done       <= 1'b0;
            o_count      <= '0;
        end else if (i_abort) begin
            o_pass_valid <= 1'b0;
        end else case (state)
            S_IDLE, S_DONE: if (i_start) begin
                max_len <= i_max_len;
                len     <= i_min_len;
                digits  <= start_digits;
                o_count <= '0;
                o_done  <= cfg_bad;
            end
            S_LOAD: begin
                o_pass       <= pack(digits, len);
                o_pass_valid <= 1'b1;
            end
            S_PRESENT: if (take) begin
                if (o_count != '1) o_count <= o_count + 48'd1;
                o_pass_valid <= 1'b0;
            end
            S_ADVANCE: begin
                if (!carry) begin
                    digits       <= inc_digits;
                    o_pass       <= pack(inc_digits, len);
                    o_pass_valid <= 1'b1;
                end else if (len != max_len) begin
                    len          <= len + 4'd1;
                    digits       <= ZERO;
                    o_pass       <= pack(ZERO, len + 4'd1);
                    o_pass_valid <= 1'b1;
                end else begin
                    o_done <= 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule
